// File: rtl/sa_rr_scheduler_3port_if.sv
// Switch-allocation bundle between route compute / out units and the 3-port
// round-robin scheduler. Master drives requests and full flags; slave is the scheduler.
interface sa_rr_scheduler_3port_if #(
  parameter int unsigned CNT_W = 16
);
  logic [2:0]       req_x_dst;
  logic [2:0]       req_y_dst;
  logic [2:0]       req_local_dst;
  logic             out_x_full;
  logic             out_y_full;
  logic             out_local_full;
  logic [2:0]       out_x_sw;
  logic [2:0]       out_y_sw;
  logic [2:0]       out_local_sw;
  logic             in_x_grant;
  logic             in_y_grant;
  logic             in_local_grant;
  logic             err_multi;
  logic [CNT_W-1:0] grant_cnt_x;
  logic [CNT_W-1:0] grant_cnt_y;
  logic [CNT_W-1:0] grant_cnt_local;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output req_x_dst, req_y_dst, req_local_dst,
    output out_x_full, out_y_full, out_local_full,
    input  out_x_sw, out_y_sw, out_local_sw,
    input  in_x_grant, in_y_grant, in_local_grant,
    input  err_multi,
    input  grant_cnt_x, grant_cnt_y, grant_cnt_local, stall_cnt
  );

  modport slave (
    input  req_x_dst, req_y_dst, req_local_dst,
    input  out_x_full, out_y_full, out_local_full,
    output out_x_sw, out_y_sw, out_local_sw,
    output in_x_grant, in_y_grant, in_local_grant,
    output err_multi,
    output grant_cnt_x, grant_cnt_y, grant_cnt_local, stall_cnt
  );
endinterface

// File: rtl/sa_rr_scheduler_3port.sv
// Registered round-robin switch allocator for the 3-port (X, Y, LOCAL) border router.
// Per-output rotating one-hot priority pointer; registered crossbar selects and pop grants.
// Optional performance counters are built only when SA_PERF_CNT_EN is defined;
// otherwise the counter ports read 0.
// Index convention everywhere: 0 = X, 1 = Y, 2 = LOCAL.
module sa_rr_scheduler_3port #(
  parameter int unsigned CNT_W            = 16,
  parameter bit          MASK_AFTER_GRANT = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sa_rr_scheduler_3port_if.slave bus
);
  localparam int unsigned NP = 3;

  logic [NP-1:0][NP-1:0] req_raw;   // [input][dst]
  logic [NP-1:0][NP-1:0] req_s;     // sanitised, at most one dst per input
  logic [NP-1:0]         full;
  logic                  multi_c;
  logic [NP-1:0][NP-1:0] elig;      // [output][input]
  logic [NP-1:0][NP-1:0] sw_d, sw_q;   // [output][input]
  logic [NP-1:0][NP-1:0] ptr_d, ptr_q; // [output] one-hot pointer
  logic [NP-1:0]         grant_d, grant_q;
  logic                  err_d, err_q;

  assign req_raw[0] = bus.req_x_dst;
  assign req_raw[1] = bus.req_y_dst;
  assign req_raw[2] = bus.req_local_dst;
  assign full       = {bus.out_local_full, bus.out_y_full, bus.out_x_full};

  // First eligible input at or after the one-hot pointer, wrapping X->Y->LOCAL->X.
  function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] req, input logic [NP-1:0] ptr);
    logic [NP-1:0] win;
    logic [NP-1:0] cand;
    logic          found;
    win   = '0;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (!found && (|(req & cand))) begin
        win   = cand;
        found = 1'b1;
      end
      cand = {cand[NP-2:0], cand[NP-1]};
    end
    return win;
  endfunction

  // Keep only the lowest destination bit per input and flag multi-hot requests.
  always_comb begin
    multi_c = 1'b0;
    req_s   = '0;
    for (int i = 0; i < NP; i++) begin
      req_s[i] = req_raw[i] & (~req_raw[i] + NP'(1));
      multi_c  = multi_c | ((req_raw[i] & (req_raw[i] - NP'(1))) != '0);
    end
  end

  // Per-output eligibility, round-robin pick, pointer advance and input grant fan-in.
  always_comb begin
    elig    = '0;
    sw_d    = '0;
    ptr_d   = ptr_q;
    grant_d = '0;
    err_d   = err_q | multi_c;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        elig[o][i] = req_s[i][o] & ~full[o] & ~(MASK_AFTER_GRANT & grant_q[i]);
      end
      sw_d[o] = rr_pick(elig[o], ptr_q[o]);
      if (|sw_d[o]) begin
        ptr_d[o] = {sw_d[o][NP-2:0], sw_d[o][NP-1]};
      end
      for (int i = 0; i < NP; i++) begin
        grant_d[i] = grant_d[i] | sw_d[o][i];
      end
    end
  end

  // Scheduler state; reset aborts any pulse and points every output back at X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q    <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      for (int o = 0; o < NP; o++) begin
        ptr_q[o] <= NP'(1);
      end
    end else begin
      sw_q    <= sw_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_x_sw       = sw_q[0];
  assign bus.out_y_sw       = sw_q[1];
  assign bus.out_local_sw   = sw_q[2];
  assign bus.in_x_grant     = grant_q[0];
  assign bus.in_y_grant     = grant_q[1];
  assign bus.in_local_grant = grant_q[2];
  assign bus.err_multi      = err_q;

`ifdef SA_PERF_CNT_EN
  logic [NP-1:0][CNT_W-1:0] gcnt_q;
  logic [CNT_W-1:0]         stall_q;
  logic                     blocked_c;

  // A cycle stalls when any full output has at least one request aimed at it.
  always_comb begin
    blocked_c = 1'b0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        blocked_c = blocked_c | (full[o] & req_s[i][o]);
      end
    end
  end

  // Wrapping grant and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (|sw_q[o]) begin
          gcnt_q[o] <= gcnt_q[o] + CNT_W'(1);
        end
      end
      if (blocked_c) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.grant_cnt_x     = gcnt_q[0];
  assign bus.grant_cnt_y     = gcnt_q[1];
  assign bus.grant_cnt_local = gcnt_q[2];
  assign bus.stall_cnt       = stall_q;
`else
  assign bus.grant_cnt_x     = CNT_W'(0);
  assign bus.grant_cnt_y     = CNT_W'(0);
  assign bus.grant_cnt_local = CNT_W'(0);
  assign bus.stall_cnt       = CNT_W'(0);
`endif
endmodule
